// File: rtl/keymatrix_mapper_if.sv
// keymatrix_mapper_if
// Scancode byte stream from a PS/2 receiver into the key-matrix mapper.
//   scan_valid : source has a byte on scan_data
//   scan_data  : PS/2 set-2 scancode byte
//   scan_ready : sink can take the byte
// Handshake: a byte transfers on the rising edge where scan_valid and
// scan_ready are both high. While scan_valid is high and scan_ready is low,
// the source holds scan_data unchanged. scan_ready does not depend on
// scan_valid.
interface keymatrix_mapper_if;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       scan_ready;

  modport master (output scan_valid, output scan_data, input scan_ready);
  modport slave  (input scan_valid, input scan_data, output scan_ready);
endinterface

// File: rtl/keymatrix_mapper.sv
// keymatrix_mapper
// Turns a PS/2 set-2 scancode stream into a ROWS x COLS key matrix that a
// retro machine scans through rowselect/rowbits. It also tracks modifier
// slots and an emulated-shift request.
// Ports:
//   clkk, reset        : clock, synchronous active-high reset
//   scan (slave)       : scancode byte handshake (see keymatrix_mapper_if)
//   map_code           : {ext, byte} lookup address to the external table
//   map_kind/row/col/shift : table result, valid one cycle after map_code
//   osd_active         : overlay owns keyboard, blocks new matrix presses
//   rowselect, rowbits : matrix scan strobe in, registered column bits out
//   mod_keys, shift_req: held modifier flags, emulated shift demand
//   o_dbg_state        : current FSM state (IDLE=0 LOOKUP=1 APPLY=2 SKIP=3)
module keymatrix_mapper #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic                clkk,
  input  logic                reset,
  keymatrix_mapper_if.slave   scan,
  output logic [8:0]          map_code,
  input  logic [1:0]          map_kind,
  input  logic [RW-1:0]       map_row,
  input  logic [CW-1:0]       map_col,
  input  logic                map_shift,
  input  logic                osd_active,
  input  logic [ROWS-1:0]     rowselect,
  output logic [COLS-1:0]     rowbits,
  output logic [COLS-1:0]     mod_keys,
  output logic                shift_req,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, APPLY = 2'd2, SKIP = 2'd3} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic                       r_brk;
  logic                       r_ext;
  logic [2:0]                 r_skip_cnt;
  logic [8:0]                 r_map_code;
  logic [ROWS-1:0][COLS-1:0]  r_matrix;
  logic [COLS-1:0]            r_rowbits;
  logic [COLS-1:0]            r_mod_keys;
  logic                       r_shift_req;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_row_ok;
  logic                       w_col_ok;
  logic [COLS-1:0]            w_rowbits;

  assign w_ready         = (r_state == IDLE) || (r_state == SKIP);
  assign scan.scan_ready = w_ready;
  assign w_accept        = scan.scan_valid && w_ready;

  // Table indices can exceed the matrix when ROWS/COLS are not powers of two.
  assign w_row_ok = (32'(map_row) < ROWS);
  assign w_col_ok = (32'(map_col) < COLS);

  assign map_code    = r_map_code;
  assign rowbits     = r_rowbits;
  assign mod_keys    = r_mod_keys;
  assign shift_req   = r_shift_req;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (scan.scan_data)
            8'hF0, 8'hE0, 8'h00, 8'hFF: w_next_state = IDLE;
            8'hE1:                      w_next_state = SKIP;
            default:                    w_next_state = LOOKUP;
          endcase
        end
      end
      LOOKUP: w_next_state = APPLY;
      APPLY:  w_next_state = IDLE;
      SKIP: begin
        if (w_accept && (r_skip_cnt == 3'd1)) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_rowbits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowselect[r]) w_rowbits = w_rowbits | r_matrix[r];
    end
  end

  always_ff @(posedge clkk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_skip_cnt  <= '0;
      r_map_code  <= '0;
      r_matrix    <= '0;
      r_rowbits   <= '0;
      r_mod_keys  <= '0;
      r_shift_req <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rowbits <= w_rowbits;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (scan.scan_data)
              8'hF0: r_brk <= 1'b1;
              8'hE0: r_ext <= 1'b1;
              8'hE1: r_skip_cnt <= 3'd7;
              8'h00, 8'hFF: begin
                // Receiver overrun: drop everything so no key sticks.
                r_matrix    <= '0;
                r_mod_keys  <= '0;
                r_shift_req <= 1'b0;
                r_brk       <= 1'b0;
                r_ext       <= 1'b0;
              end
              default: r_map_code <= {r_ext, scan.scan_data};
            endcase
          end
        end
        SKIP: begin
          if (w_accept) r_skip_cnt <= r_skip_cnt - 3'd1;
        end
        APPLY: begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          case (map_kind)
            2'b01: begin
              if (w_row_ok && w_col_ok) begin
                if (!r_brk) begin
                  // The overlay blocks new presses, but releases still land so
                  // keys held before it opened do not stick.
                  if (!osd_active) begin
                    r_matrix[map_row][map_col] <= 1'b1;
                    if (map_shift) r_shift_req <= 1'b1;
                  end
                end else begin
                  r_matrix[map_row][map_col] <= 1'b0;
                  if (map_shift) r_shift_req <= 1'b0;
                end
              end
            end
            2'b10: begin
              if (w_col_ok) r_mod_keys[map_col] <= ~r_brk;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keymatrix_mapper.sv
module tb_keymatrix_mapper;

  logic       clkk;
  logic       reset;
  logic [8:0] map_code;
  logic [1:0] map_kind;
  logic [2:0] map_row;
  logic [2:0] map_col;
  logic       map_shift;
  logic       osd_active;
  logic [7:0] rowselect;
  logic [7:0] rowbits;
  logic [7:0] mod_keys;
  logic       shift_req;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  keymatrix_mapper_if u_if ();

  keymatrix_mapper #(.ROWS(8), .COLS(8)) u_dut (
    .clkk        (clkk),
    .reset       (reset),
    .scan        (u_if),
    .map_code    (map_code),
    .map_kind    (map_kind),
    .map_row     (map_row),
    .map_col     (map_col),
    .map_shift   (map_shift),
    .osd_active  (osd_active),
    .rowselect   (rowselect),
    .rowbits     (rowbits),
    .mod_keys    (mod_keys),
    .shift_req   (shift_req),
    .o_dbg_state (dbg_state)
  );

  // clock/reset
  initial clkk = 1'b0;
  always #5 clkk = ~clkk;

  // external mapping table, registered one cycle after map_code
  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] row;
    logic [2:0] col;
    logic       shift;
  } map_t;

  function automatic map_t tbl(input logic [8:0] code);
    case (code)
      9'h01C:  return '{2'b01, 3'd2, 3'd3, 1'b0};
      9'h175:  return '{2'b01, 3'd1, 3'd5, 1'b1};
      9'h012:  return '{2'b10, 3'd0, 3'd0, 1'b0};
      9'h059:  return '{2'b10, 3'd0, 3'd1, 1'b0};
      9'h014:  return '{2'b10, 3'd0, 3'd2, 1'b0};
      9'h015:  return '{2'b01, 3'd0, 3'd0, 1'b0};
      9'h01D:  return '{2'b01, 3'd0, 3'd1, 1'b0};
      9'h024:  return '{2'b01, 3'd3, 3'd7, 1'b1};
      9'h02D:  return '{2'b01, 3'd7, 3'd7, 1'b0};
      9'h011:  return '{2'b11, 3'd4, 3'd4, 1'b0};
      9'h114:  return '{2'b01, 3'd6, 3'd2, 1'b0};
      default: return '{2'b00, 3'd0, 3'd0, 1'b0};
    endcase
  endfunction

  map_t map_r;
  always @(posedge clkk) map_r <= tbl(map_code);
  assign map_kind  = map_r.kind;
  assign map_row   = map_r.row;
  assign map_col   = map_r.col;
  assign map_shift = map_r.shift;

  // behavioural model: byte-level interpretation of the scancode rules
  logic [7:0] m_mat [8];
  logic [7:0] m_mod;
  logic       m_shift, m_brk, m_ext;
  int         m_skip;

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_mat[r] = 8'h00;
    m_mod = 8'h00; m_shift = 1'b0; m_brk = 1'b0; m_ext = 1'b0; m_skip = 0;
  endtask

  task automatic model_apply(input logic [7:0] b, input logic osd);
    map_t m;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'h00 || b == 8'hFF) begin
      model_reset();
    end else begin
      m = tbl({m_ext, b});
      if (m.kind == 2'b01) begin
        if (m_brk) begin
          m_mat[m.row][m.col] = 1'b0;
          if (m.shift) m_shift = 1'b0;
        end else if (!osd) begin
          m_mat[m.row][m.col] = 1'b1;
          if (m.shift) m_shift = 1'b1;
        end
      end else if (m.kind == 2'b10) begin
        m_mod[m.col] = !m_brk;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_rowbits(input logic [7:0] rs);
    logic [7:0] acc = 8'h00;
    for (int r = 0; r < 8; r++) if (rs[r]) acc = acc | m_mat[r];
    return acc;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drivers
  task automatic do_reset();
    reset = 1'b1;
    u_if.scan_valid = 1'b0;
    repeat (2) @(posedge clkk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clkk);
    while (!u_if.scan_ready && n < 100) begin
      @(negedge clkk);
      n++;
    end
    if (!u_if.scan_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    u_if.scan_valid = 1'b1;
    u_if.scan_data  = b;
    @(posedge clkk);
    #1 u_if.scan_valid = 1'b0;
    model_apply(b, osd_active);
  endtask

  task automatic settle();
    repeat (2) @(posedge clkk);
    #1;
  endtask

  task automatic check_keys(input string nm, input logic [7:0] rs);
    rowselect = rs;
    @(posedge clkk);
    #1;
    chk({nm, "_rowbits"}, rowbits, model_rowbits(rs));
    chk({nm, "_mod"}, mod_keys, m_mod);
    chk({nm, "_shift"}, shift_req, m_shift);
  endtask

  // directed vectors, applied cumulatively from reset
  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       osd;
    logic [7:0] rs;
    logic [7:0] exp_rowbits;
    logic [7:0] exp_mod;
    logic       exp_shift;
  } vec_t;

  vec_t vecs [16];
  logic [7:0] pool [16];

  initial begin
    vecs[0]  = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 8'h04, 8'h08, 8'h00, 1'b0};
    vecs[1]  = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{8'hE0, 8'h75, 8'h00, 2, 1'b0, 8'h02, 8'h20, 8'h00, 1'b1};
    vecs[3]  = '{8'hE0, 8'hF0, 8'h75, 3, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{8'h12, 8'h00, 8'h00, 1, 1'b0, 8'hFF, 8'h00, 8'h01, 1'b0};
    vecs[5]  = '{8'hF0, 8'h12, 8'h00, 2, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{8'h12, 8'h00, 8'h00, 1, 1'b1, 8'hFF, 8'h00, 8'h01, 1'b0};
    vecs[7]  = '{8'hF0, 8'h12, 8'h00, 2, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{8'h1C, 8'h00, 8'h00, 1, 1'b1, 8'h04, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{8'h11, 8'h00, 8'h00, 1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{8'h24, 8'h00, 8'h00, 1, 1'b0, 8'h08, 8'h80, 8'h00, 1'b1};
    vecs[11] = '{8'h24, 8'h00, 8'h00, 1, 1'b0, 8'h08, 8'h80, 8'h00, 1'b1};
    vecs[12] = '{8'hF0, 8'h15, 8'h00, 2, 1'b0, 8'h09, 8'h80, 8'h00, 1'b1};
    vecs[13] = '{8'hF0, 8'h24, 8'h00, 2, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[14] = '{8'hE0, 8'h14, 8'h00, 2, 1'b0, 8'h40, 8'h04, 8'h00, 1'b0};
    vecs[15] = '{8'hE0, 8'hF0, 8'h14, 3, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0};

    pool = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1C, 8'h12, 8'h14, 8'h59,
             8'h11, 8'h33, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hFF};

    reset = 1'b1;
    osd_active = 1'b0;
    rowselect = 8'h00;
    u_if.scan_valid = 1'b0;
    u_if.scan_data = 8'h00;
    do_reset();

    // reset state
    @(posedge clkk); #1;
    chk("rst_rowbits", rowbits, 8'h00);
    chk("rst_mod", mod_keys, 8'h00);
    chk("rst_shift", shift_req, 1'b0);
    chk("rst_ready", u_if.scan_ready, 1'b1);
    chk("rst_map_code", map_code, 9'h000);
    chk("rst_state", dbg_state, 2'd0);

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      osd_active = vecs[i].osd;
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      settle();
      rowselect = vecs[i].rs;
      @(posedge clkk); #1;
      chk($sformatf("vec%0d_rowbits", i), rowbits, vecs[i].exp_rowbits);
      chk($sformatf("vec%0d_mod", i), mod_keys, vecs[i].exp_mod);
      chk($sformatf("vec%0d_shift", i), shift_req, vecs[i].exp_shift);
    end
    osd_active = 1'b0;

    // cycle-exact latency of one make code
    rowselect = 8'h04;
    @(negedge clkk);
    u_if.scan_valid = 1'b1;
    u_if.scan_data = 8'h1C;
    @(posedge clkk); #1;
    u_if.scan_valid = 1'b0;
    model_apply(8'h1C, 1'b0);
    chk("lat_t0_ready", u_if.scan_ready, 1'b0);
    chk("lat_t0_map_code", map_code, 9'h01C);
    chk("lat_t0_state", dbg_state, 2'd1);
    @(posedge clkk); #1;
    chk("lat_t1_ready", u_if.scan_ready, 1'b0);
    chk("lat_t1_map_code", map_code, 9'h01C);
    chk("lat_t1_state", dbg_state, 2'd2);
    @(posedge clkk); #1;
    chk("lat_t2_ready", u_if.scan_ready, 1'b1);
    chk("lat_t2_rowbits", rowbits, 8'h00);
    @(posedge clkk); #1;
    chk("lat_t3_rowbits", rowbits, 8'h08);
    send_byte(8'hF0);
    send_byte(8'h1C);
    settle();

    // extended code address
    send_byte(8'hE0);
    send_byte(8'h75);
    chk("ext_map_code", map_code, 9'h175);
    settle();
    check_keys("ext_make", 8'h02);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    settle();
    check_keys("ext_break", 8'h02);

    // key held before the overlay opens is still released
    send_byte(8'h1C);
    settle();
    osd_active = 1'b1;
    send_byte(8'hF0);
    send_byte(8'h1C);
    settle();
    rowselect = 8'h04;
    @(posedge clkk); #1;
    chk("osd_release_rowbits", rowbits, 8'h00);
    osd_active = 1'b0;

    // Pause sequence discarded, overrun clears all
    send_byte(8'h24);
    foreach (pool[k]) ;
    begin
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    end
    send_byte(8'h1C);
    settle();
    rowselect = 8'hFF;
    @(posedge clkk); #1;
    chk("pause_rowbits", rowbits, 8'h88);
    chk("pause_mod", mod_keys, 8'h00);
    chk("pause_shift", shift_req, 1'b1);
    chk("pause_state", dbg_state, 2'd0);
    send_byte(8'hFF);
    settle();
    @(posedge clkk); #1;
    chk("overrun_rowbits", rowbits, 8'h00);
    chk("overrun_shift", shift_req, 1'b0);

    // byte presented while busy is held, then taken exactly once
    send_byte(8'h1C);
    u_if.scan_valid = 1'b1;
    u_if.scan_data = 8'h2D;
    @(posedge clkk); #1;
    chk("hold_t1_map_code", map_code, 9'h01C);
    @(posedge clkk); #1;
    chk("hold_t2_map_code", map_code, 9'h01C);
    @(posedge clkk); #1;
    u_if.scan_valid = 1'b0;
    model_apply(8'h2D, osd_active);
    chk("hold_t3_map_code", map_code, 9'h02D);
    settle();
    check_keys("hold_keys", 8'h84);

    // reset while in APPLY with keys held
    send_byte(8'h24);
    settle();
    rowselect = 8'hFF;
    @(negedge clkk);
    u_if.scan_valid = 1'b1;
    u_if.scan_data = 8'h15;
    @(posedge clkk); #1;
    u_if.scan_valid = 1'b0;
    @(posedge clkk); #1;
    chk("pre_rst_state", dbg_state, 2'd2);
    reset = 1'b1;
    @(posedge clkk); #1;
    reset = 1'b0;
    model_reset();
    chk("apply_rst_rowbits", rowbits, 8'h00);
    chk("apply_rst_ready", u_if.scan_ready, 1'b1);
    chk("apply_rst_state", dbg_state, 2'd0);
    chk("apply_rst_shift", shift_req, 1'b0);
    @(posedge clkk); #1;
    chk("apply_rst_rowbits2", rowbits, 8'h00);
    send_byte(8'h1C);
    settle();
    rowselect = 8'h04;
    @(posedge clkk); #1;
    chk("post_rst_rowbits", rowbits, 8'h08);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      osd_active = ($urandom_range(0, 3) == 0);
      send_byte(pool[$urandom_range(0, 15)]);
      settle();
      check_keys("rand", 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
